// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port Avalon-MM arbiter for the shared SDRAM master, with read-tag steering
// Build option: SDRAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority on ties (default round-robin).
module sdram_arbiter #(
   parameter int MAX_PENDING = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [31:0]                   m0_address,
   input  logic                          m0_read,
   input  logic                          m0_write,
   input  logic [31:0]                   m0_writedata,
   output logic                          m0_waitrequest,
   output logic [31:0]                   m0_readdata,
   output logic                          m0_readdatavalid,
   input  logic [31:0]                   m1_address,
   input  logic                          m1_read,
   input  logic                          m1_write,
   input  logic [31:0]                   m1_writedata,
   output logic                          m1_waitrequest,
   output logic [31:0]                   m1_readdata,
   output logic                          m1_readdatavalid,
   input  logic                          s_waitrequest,
   input  logic [31:0]                   s_readdata,
   input  logic                          s_readdatavalid,
   output logic [31:0]                   s_address,
   output logic                          s_read,
   output logic                          s_write,
   output logic [31:0]                   s_writedata,
   output logic [$clog2(MAX_PENDING):0]  pending,
   output logic                          err_orphan
);

   localparam int PW = $clog2(MAX_PENDING);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT0 = 2'd1;
   localparam logic [1:0] ST_GRANT1 = 2'd2;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic                   req0;
   logic                   req1;
   logic                   tie_to_0;
   logic                   gnt_read;
   logic                   gnt_write;
   logic                   grant_tag;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW:0]            count;
   logic [MAX_PENDING-1:0] tag_mem;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   head_tag;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   assign fifo_full  = (count == (PW+1)'(MAX_PENDING));
   assign fifo_empty = (count == '0);
   assign head_tag   = tag_mem[rd_ptr];

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   assign tie_to_0 = 1'b1;
`else
   // last = port granted most recently; a tie goes to the other one
   logic last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (state == ST_IDLE && (req0 || req1)) begin
         last <= (state_nxt == ST_GRANT1);
      end
   end

   assign tie_to_0 = last;
`endif

   always_comb begin
      s_address      = '0;
      s_writedata    = '0;
      gnt_read       = 1'b0;
      gnt_write      = 1'b0;
      grant_tag      = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (state)
         ST_GRANT0: begin
            s_address      = m0_address;
            s_writedata    = m0_writedata;
            gnt_read       = m0_read;
            gnt_write      = m0_write;
            m0_waitrequest = s_waitrequest | (m0_read & fifo_full);
         end
         ST_GRANT1: begin
            s_address      = m1_address;
            s_writedata    = m1_writedata;
            gnt_read       = m1_read;
            gnt_write      = m1_write;
            grant_tag      = 1'b1;
            m1_waitrequest = s_waitrequest | (m1_read & fifo_full);
         end
         default: ;
      endcase
      // the full gate uses the registered count, so a same-cycle pop cannot open it
      s_read  = gnt_read & ~fifo_full;
      s_write = gnt_write;
   end

   assign accept = (s_read | s_write) & ~s_waitrequest;
   assign push   = s_read & ~s_waitrequest;
   assign pop    = s_readdatavalid & ~fifo_empty;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req0 && (!req1 || tie_to_0)) begin
               state_nxt = ST_GRANT0;
            end else if (req1) begin
               state_nxt = ST_GRANT1;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            if (accept || !(gnt_read || gnt_write)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         tag_mem    <= '0;
         err_orphan <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) begin
            tag_mem[wr_ptr] <= grant_tag;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (s_readdatavalid && fifo_empty) begin
            err_orphan <= 1'b1;
         end
      end
   end

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & ~head_tag;
   assign m1_readdatavalid = s_readdatavalid & ~fifo_empty &  head_tag;
   assign pending          = count;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - randomized self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

   localparam int MAXP = 2;

   logic                   clk;
   logic                   rst_n;
   logic [31:0]            m0_address, m1_address;
   logic                   m0_read, m1_read, m0_write, m1_write;
   logic [31:0]            m0_writedata, m1_writedata;
   logic                   m0_waitrequest, m1_waitrequest;
   logic [31:0]            m0_readdata, m1_readdata;
   logic                   m0_readdatavalid, m1_readdatavalid;
   logic                   s_waitrequest;
   logic [31:0]            s_readdata;
   logic                   s_readdatavalid;
   logic [31:0]            s_address;
   logic                   s_read, s_write;
   logic [31:0]            s_writedata;
   logic [$clog2(MAXP):0]  pending;
   logic                   err_orphan;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   typedef struct {
      int          port;
      logic [31:0] addr;
   } rd_t;

   req_t        rq0[$];
   req_t        rq1[$];
   rd_t         ds_q[$];
   int          grant_log[$];
   logic [31:0] ret0[$];
   logic [31:0] ret1[$];
   int          n_cmp = 0;
   int          n_fail = 0;

   sdram_arbiter #(.MAX_PENDING(MAXP)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
      .pending(pending), .err_orphan(err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[15:0]};
   endfunction

   task automatic apply_reset;
      rst_n = 1'b0;
      m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
      m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
      s_waitrequest = 1'b1; s_readdata = '0; s_readdatavalid = 1'b0;
      rq0.delete(); rq1.delete(); ds_q.delete(); grant_log.delete(); ret0.delete(); ret1.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // requester presents one command and holds it until its waitrequest is low
   task automatic do_cmd(input int port, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int budget, output bit ok);
      ok = 1'b0;
      @(posedge clk); #1;
      if (port == 0) begin
         m0_address = addr; m0_writedata = data; m0_read = !wr; m0_write = wr;
      end else begin
         m1_address = addr; m1_writedata = data; m1_read = !wr; m1_write = wr;
      end
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = (port == 0) ? !m0_waitrequest : !m1_waitrequest;
         if (!ok) begin
            @(posedge clk); #1;
         end
      end
      if (ok) begin
         @(posedge clk); #1;
      end
      if (port == 0) begin
         m0_read = 1'b0; m0_write = 1'b0;
      end else begin
         m1_read = 1'b0; m1_write = 1'b0;
      end
   endtask

   // traffic engine: requester queues on both ports, in-order downstream memory with random stalls
   task automatic run_traffic(input int wait_pct, input int rdv_pct, input int max_cycles);
      int  cyc;
      bit  acc0, acc1;
      rd_t r;
      cyc = 0;
      while ((rq0.size() > 0 || rq1.size() > 0 || ds_q.size() > 0) && cyc < max_cycles) begin
         @(posedge clk); #1;
         cyc++;
         if (rq0.size() > 0) begin
            m0_read = !rq0[0].wr; m0_write = rq0[0].wr; m0_address = rq0[0].addr; m0_writedata = rq0[0].data;
         end else begin
            m0_read = 1'b0; m0_write = 1'b0;
         end
         if (rq1.size() > 0) begin
            m1_read = !rq1[0].wr; m1_write = rq1[0].wr; m1_address = rq1[0].addr; m1_writedata = rq1[0].data;
         end else begin
            m1_read = 1'b0; m1_write = 1'b0;
         end
         s_waitrequest = ($urandom_range(99) < wait_pct);
         if (ds_q.size() > 0 && $urandom_range(99) < rdv_pct) begin
            s_readdatavalid = 1'b1; s_readdata = mem_data(ds_q[0].addr);
         end else begin
            s_readdatavalid = 1'b0; s_readdata = $urandom;
         end
         @(negedge clk);
         acc0 = (m0_read || m0_write) && !m0_waitrequest;
         acc1 = (m1_read || m1_write) && !m1_waitrequest;
         n_cmp++;
         if ((acc0 || acc1) !== ((s_read || s_write) && !s_waitrequest)) begin
            n_fail++;
            $display("FAIL handshake cyc=%0d: port_accept=%0b downstream_accept=%0b", cyc, acc0 || acc1,
                     (s_read || s_write) && !s_waitrequest);
         end
         n_cmp++;
         if (acc0 && acc1) begin
            n_fail++; $display("FAIL double_grant cyc=%0d: both ports accepted, required at most one", cyc);
         end
         n_cmp++;
         if (int'(pending) !== ds_q.size()) begin
            n_fail++; $display("FAIL pending cyc=%0d: got %0d required %0d", cyc, pending, ds_q.size());
         end
         if (ds_q.size() == MAXP) begin
            n_cmp++;
            if (s_read !== 1'b0) begin
               n_fail++; $display("FAIL full_gate cyc=%0d: s_read=%0b required 0", cyc, s_read);
            end
         end
         n_cmp++;
         if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin
            n_fail++; $display("FAIL broadcast cyc=%0d: m0=%h m1=%h required %h", cyc, m0_readdata, m1_readdata, s_readdata);
         end
         if (s_readdatavalid) begin
            r = ds_q.pop_front();
            n_cmp++;
            if ({m1_readdatavalid, m0_readdatavalid} !== ((r.port == 1) ? 2'b10 : 2'b01) ||
                s_readdata !== mem_data(r.addr)) begin
               n_fail++;
               $display("FAIL steer cyc=%0d: rdv={m1,m0}=%b data=%h required owner port %0d data %h", cyc,
                        {m1_readdatavalid, m0_readdatavalid}, s_readdata, r.port, mem_data(r.addr));
            end
            if (r.port == 0) ret0.push_back(m0_readdata);
            else             ret1.push_back(m1_readdata);
         end else begin
            n_cmp++;
            if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin
               n_fail++; $display("FAIL idle_rdv cyc=%0d: rdv={m1,m0}=%b required 00", cyc, {m1_readdatavalid, m0_readdatavalid});
            end
         end
         if (acc0) begin
            n_cmp++;
            if ({s_address, s_read, s_write, s_writedata} !== {m0_address, m0_read, m0_write, m0_write ? m0_writedata : s_writedata}) begin
               n_fail++; $display("FAIL cmd0 cyc=%0d: s_addr=%h rd=%0b wr=%0b wdata=%h required %h %0b %0b %h", cyc,
                                  s_address, s_read, s_write, s_writedata, m0_address, m0_read, m0_write, m0_writedata);
            end
            grant_log.push_back(0);
            if (m0_read) begin
               r.port = 0; r.addr = m0_address; ds_q.push_back(r);
            end
            rq0.delete(0);
         end
         if (acc1) begin
            n_cmp++;
            if ({s_address, s_read, s_write, s_writedata} !== {m1_address, m1_read, m1_write, m1_write ? m1_writedata : s_writedata}) begin
               n_fail++; $display("FAIL cmd1 cyc=%0d: s_addr=%h rd=%0b wr=%0b wdata=%h required %h %0b %0b %h", cyc,
                                  s_address, s_read, s_write, s_writedata, m1_address, m1_read, m1_write, m1_writedata);
            end
            grant_log.push_back(1);
            if (m1_read) begin
               r.port = 1; r.addr = m1_address; ds_q.push_back(r);
            end
            rq1.delete(0);
         end
      end
      n_cmp++;
      if (rq0.size() + rq1.size() + ds_q.size() != 0) begin
         n_fail++; $display("FAIL traffic_timeout: %0d items left after %0d cycles, required 0",
                            rq0.size() + rq1.size() + ds_q.size(), cyc);
      end
      @(posedge clk); #1;
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      s_readdatavalid = 1'b0; s_waitrequest = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      m0_address = 32'h0000_0ABC; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = 32'h1234_5678;
      m1_address = 32'h0000_0DEF; m1_read = 1'b0; m1_write = 1'b1; m1_writedata = 32'h8765_4321;
      s_waitrequest = 1'b0; s_readdata = 32'hFFFF_0000; s_readdatavalid = 1'b1;
      #12;
      n_cmp++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 6'b001100) begin
         n_fail++; $display("FAIL reset_ctrl: rd,wr,wr0,wr1,rdv0,rdv1=%b required 001100",
                            {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid});
      end
      n_cmp++;
      if (s_address !== 32'h0 || s_writedata !== 32'h0) begin
         n_fail++; $display("FAIL reset_bus: s_address=%h s_writedata=%h required 0", s_address, s_writedata);
      end
      n_cmp++;
      if (int'(pending) !== 0 || err_orphan !== 1'b0) begin
         n_fail++; $display("FAIL reset_regs: pending=%0d err_orphan=%0b required 0 0", pending, err_orphan);
      end
      apply_reset();
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 0 || err_orphan !== 1'b0 || m0_waitrequest !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_idle: pending=%0d err_orphan=%0b wr0=%0b required 0 0 1",
                            pending, err_orphan, m0_waitrequest);
      end
   endtask

   task automatic test_single_read;
      int seen;
      bit done;
      seen = 0;
      done = 1'b0;
      apply_reset();
      @(posedge clk); #1;
      m0_address = 32'h0000_0010; m0_read = 1'b1; s_waitrequest = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin
         n_fail++; $display("FAIL arb_idle: s_read=%0b wr0=%0b required 0 1", s_read, m0_waitrequest);
      end
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk); #1;
         s_waitrequest = (seen < 3);
         @(negedge clk);
         if (i == 0) begin
            n_cmp++;
            if (s_read !== 1'b1 || s_address !== 32'h0000_0010) begin
               n_fail++; $display("FAIL arb_latency: s_read=%0b s_address=%h required 1 00000010", s_read, s_address);
            end
         end
         if (s_read) begin
            if (!s_waitrequest) done = 1'b1;
            seen++;
         end
      end
      n_cmp++;
      if (!done || seen != 4 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
         n_fail++; $display("FAIL single_accept: done=%0b cycles_on_bus=%0d wr0=%0b wr1=%0b required 1 4 0 1",
                            done, seen, m0_waitrequest, m1_waitrequest);
      end
      @(posedge clk); #1;
      m0_read = 1'b0; s_waitrequest = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 1) begin
         n_fail++; $display("FAIL single_pending: got %0d required 1", pending);
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b1; s_readdata = mem_data(32'h0000_0010);
      @(negedge clk);
      n_cmp++;
      if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h0010_0010) begin
         n_fail++; $display("FAIL single_data: rdv0=%0b rdv1=%0b data=%h required 1 0 00100010",
                            m0_readdatavalid, m1_readdatavalid, m0_readdata);
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 0 || m0_readdatavalid !== 1'b0) begin
         n_fail++; $display("FAIL single_drain: pending=%0d rdv0=%0b required 0 0", pending, m0_readdatavalid);
      end
   endtask

   task automatic test_tie_round_robin;
      int   exp_log[$];
      req_t q;
      apply_reset();
      q.wr = 1'b0; q.data = '0;
      q.addr = 32'h20; rq0.push_back(q);
      q.addr = 32'h24; rq0.push_back(q);
      q.addr = 32'h30; rq1.push_back(q);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      exp_log = '{0, 0, 1};
`else
      exp_log = '{0, 1, 0};
`endif
      run_traffic(0, 100, 100);
      n_cmp++;
      if (grant_log.size() != 3) begin
         n_fail++; $display("FAIL tie_count: %0d grants required 3", grant_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (grant_log[i] != exp_log[i]) begin
               n_fail++; $display("FAIL tie_order[%0d]: granted port %0d required %0d", i, grant_log[i], exp_log[i]);
            end
         end
      end
      n_cmp++;
      if (ret0.size() != 2 || ret1.size() != 1) begin
         n_fail++; $display("FAIL tie_returns: port0 %0d port1 %0d required 2 1", ret0.size(), ret1.size());
      end else begin
         n_cmp++;
         if (ret0[0] !== 32'h0020_0020 || ret1[0] !== 32'h0030_0030) begin
            n_fail++; $display("FAIL tie_data: port0 %h port1 %h required 00200020 00300030", ret0[0], ret1[0]);
         end
      end
   endtask

   task automatic test_fifo_full;
      bit ok;
      apply_reset();
      s_waitrequest = 1'b0;
      for (int k = 0; k < 2; k++) begin
         do_cmd(0, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 6, ok);
         n_cmp++;
         if (!ok) begin
            n_fail++; $display("FAIL full_fill[%0d]: read not accepted, required accepted", k);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 2) begin
         n_fail++; $display("FAIL full_pending: got %0d required 2", pending);
      end
      @(posedge clk); #1;
      m0_address = 32'h108; m0_read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++;
         if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || int'(pending) !== 2) begin
            n_fail++; $display("FAIL full_block[%0d]: s_read=%0b wr0=%0b pending=%0d required 0 1 2",
                               k, s_read, m0_waitrequest, pending);
         end
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b1; s_readdata = mem_data(32'h100);
      @(negedge clk);
      n_cmp++;
      if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h0100_0100) begin
         n_fail++; $display("FAIL full_pop: rdv0=%0b rdv1=%0b data=%h required 1 0 01000100",
                            m0_readdatavalid, m1_readdatavalid, m0_readdata);
      end
      ok = 1'b0;
      for (int i = 0; i < 2 && !ok; i++) begin
         @(posedge clk); #1;
         s_readdatavalid = 1'b0;
         @(negedge clk);
         ok = s_read && !m0_waitrequest && (s_address == 32'h108);
      end
      n_cmp++;
      if (!ok) begin
         n_fail++; $display("FAIL full_release: third read not accepted within 2 cycles, required accepted");
      end
      @(posedge clk); #1;
      m0_read = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 2) begin
         n_fail++; $display("FAIL full_refill: pending=%0d required 2", pending);
      end
   endtask

   task automatic test_write_full;
      bit ok;
      apply_reset();
      s_waitrequest = 1'b0;
      do_cmd(0, 1'b0, 32'h200, 32'h0, 6, ok);
      do_cmd(0, 1'b0, 32'h204, 32'h0, 6, ok);
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 2) begin
         n_fail++; $display("FAIL wf_pending: got %0d required 2", pending);
      end
      @(posedge clk); #1;
      m1_address = 32'h40; m1_writedata = 32'hDEAD_BEEF; m1_write = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 4 && !ok; i++) begin
         @(negedge clk);
         if (!m1_waitrequest) begin
            ok = 1'b1;
            n_cmp++;
            if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h40 || s_writedata !== 32'hDEAD_BEEF) begin
               n_fail++; $display("FAIL wf_bus: wr=%0b rd=%0b addr=%h data=%h required 1 0 00000040 deadbeef",
                                  s_write, s_read, s_address, s_writedata);
            end
         end else begin
            @(posedge clk); #1;
         end
      end
      n_cmp++;
      if (!ok) begin
         n_fail++; $display("FAIL wf_accept: write blocked by full FIFO, required accepted");
      end
      @(posedge clk); #1;
      m1_write = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 2) begin
         n_fail++; $display("FAIL wf_pending_after: got %0d required 2", pending);
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         s_readdatavalid = 1'b1; s_readdata = mem_data(32'h200 + 32'(4 * k));
         @(negedge clk);
         n_cmp++;
         if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL wf_steer[%0d]: rdv0=%0b rdv1=%0b required 1 0", k, m0_readdatavalid, m1_readdatavalid);
         end
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 0) begin
         n_fail++; $display("FAIL wf_drain: pending=%0d required 0", pending);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      apply_reset();
      s_waitrequest = 1'b0;
      do_cmd(1, 1'b0, 32'h70, 32'h0, 6, ok);
      @(posedge clk); #1;
      s_waitrequest = 1'b1; m1_address = 32'h74; m1_read = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (!ok || s_read !== 1'b1 || m1_waitrequest !== 1'b1 || int'(pending) !== 1) begin
         n_fail++; $display("FAIL rm_setup: ok=%0b s_read=%0b wr1=%0b pending=%0d required 1 1 1 1",
                            ok, s_read, m1_waitrequest, pending);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011 || s_address !== 32'h0 ||
          int'(pending) !== 0 || err_orphan !== 1'b0) begin
         n_fail++; $display("FAIL rm_async: rd,wr,wr0,wr1=%b addr=%h pending=%0d err=%0b required 0011 0 0 0",
                            {s_read, s_write, m0_waitrequest, m1_waitrequest}, s_address, pending, err_orphan);
      end
      m1_read = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      s_readdatavalid = 1'b1; s_readdata = mem_data(32'h70);
      @(negedge clk);
      n_cmp++;
      if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         n_fail++; $display("FAIL rm_stray_rdv: rdv0=%0b rdv1=%0b required 0 0", m0_readdatavalid, m1_readdatavalid);
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (err_orphan !== 1'b1) begin
         n_fail++; $display("FAIL rm_orphan: err_orphan=%0b required 1", err_orphan);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (err_orphan !== 1'b1 || int'(pending) !== 0) begin
         n_fail++; $display("FAIL rm_sticky: err_orphan=%0b pending=%0d required 1 0", err_orphan, pending);
      end
   endtask

   task automatic test_push_pop;
      apply_reset();
      s_waitrequest = 1'b0;
      @(posedge clk); #1;
      m1_address = 32'h50; m1_read = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (s_read !== 1'b1 || m1_waitrequest !== 1'b0) begin
         n_fail++; $display("FAIL pp_first: s_read=%0b wr1=%0b required 1 0", s_read, m1_waitrequest);
      end
      @(posedge clk); #1;
      m1_read = 1'b0; m0_address = 32'h60; m0_read = 1'b1;
      @(posedge clk); #1;
      s_readdatavalid = 1'b1; s_readdata = mem_data(32'h50);
      @(negedge clk);
      n_cmp++;
      if (s_read !== 1'b1 || m0_waitrequest !== 1'b0 || m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 ||
          int'(pending) !== 1) begin
         n_fail++; $display("FAIL pp_same_cycle: s_read=%0b wr0=%0b rdv1=%0b rdv0=%0b pending=%0d required 1 0 1 0 1",
                            s_read, m0_waitrequest, m1_readdatavalid, m0_readdatavalid, pending);
      end
      @(posedge clk); #1;
      m0_read = 1'b0; s_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 1) begin
         n_fail++; $display("FAIL pp_pending: got %0d required 1", pending);
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b1; s_readdata = mem_data(32'h60);
      @(negedge clk);
      n_cmp++;
      if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h0060_0060) begin
         n_fail++; $display("FAIL pp_new_tag: rdv0=%0b rdv1=%0b data=%h required 1 0 00600060",
                            m0_readdatavalid, m1_readdatavalid, m0_readdata);
      end
      @(posedge clk); #1;
      s_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 0 || err_orphan !== 1'b0) begin
         n_fail++; $display("FAIL pp_drain: pending=%0d err=%0b required 0 0", pending, err_orphan);
      end
   endtask

   task automatic test_random;
      req_t q;
      int   nrd0, nrd1;
      nrd0 = 0;
      nrd1 = 0;
      apply_reset();
      for (int i = 0; i < 25; i++) begin
         q.wr = 1'($urandom_range(1)); q.addr = $urandom & 32'hFFFF_FFFC; q.data = $urandom;
         rq0.push_back(q);
         if (!q.wr) nrd0++;
         q.wr = 1'($urandom_range(1)); q.addr = $urandom & 32'hFFFF_FFFC; q.data = $urandom;
         rq1.push_back(q);
         if (!q.wr) nrd1++;
      end
      run_traffic(30, 40, 3000);
      n_cmp++;
      if (grant_log.size() != 50 || ret0.size() != nrd0 || ret1.size() != nrd1) begin
         n_fail++; $display("FAIL rand_totals: grants %0d reads0 %0d reads1 %0d required 50 %0d %0d",
                            grant_log.size(), ret0.size(), ret1.size(), nrd0, nrd1);
      end
      @(negedge clk);
      n_cmp++;
      if (int'(pending) !== 0 || err_orphan !== 1'b0) begin
         n_fail++; $display("FAIL rand_end: pending=%0d err=%0b required 0 0", pending, err_orphan);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie_round_robin();
      test_fifo_full();
      test_write_full();
      test_push_pop();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
